difftest_commit_serializer: RTL and testbench
=============================================

# difftest_commit_serializer

- Buffers per-cycle retirement and interrupt events from a multi-lane core.
- Serialises them, in program order, into a single-entry-per-cycle valid/ready stream toward the co-simulation step checker.
- Latches the first checker failure and gates end-of-test until every buffered commit has been checked.
- Sits between the core commit probe and the DPI checker shim in the testbench; successor to the single-shot per-cycle stepping scheme.

## Interface
- COMMIT_WIDTH, 2, commit lanes per cycle
- XLEN, 64, data/pc/status width
- INST_BITS, 32, instruction width
- HARTID_LEN, 1, hart id width
- DEPTH, 16, queue entries; power of two, ≥ COMMIT_WIDTH+1
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- in_valid  in  COMMIT_WIDTH  per-lane commit valid; lane 0 oldest
- hartid  in  HARTID_LEN  hart of this cycle's events
- pc / wdata / mstatus  in  XLEN*COMMIT_WIDTH  per-lane fields; lane i at [(i+1)*XLEN-1 -: XLEN]
- inst  in  INST_BITS*COMMIT_WIDTH  per-lane instruction
- check  in  COMMIT_WIDTH  per-lane compare enable
- int_xcpt  in  1  interrupt/trap taken this cycle
- cause  in  XLEN  trap cause
- tohost  in  XLEN  host mailbox; bit 0 requests finish
- out_valid  out  1  head entry available
- out_ready  in  1  checker accepts head
- out_kind  out  1  0 = commit, 1 = trap
- out_hartid  out  HARTID_LEN
- out_pc, out_wdata, out_mstatus  out  XLEN  commit fields; out_wdata carries cause when out_kind=1
- out_inst  out  INST_BITS
- out_check  out  1
- chk_valid  in  1  checker result strobe
- chk_code  in  32  checker result; nonzero = mismatch
- count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: a cycle's events were dropped
- fail  out  1  sticky: nonzero chk_code seen
- fail_code  out  32  first nonzero chk_code
- finish  out  1  end of test

## Operation
- **Enqueue:** each cycle, n = popcount(in_valid) + int_xcpt entries.
  - Order: valid lanes ascending, compacted (gaps removed), then the trap entry.
  - All entries share this cycle's hartid.
- **All-or-nothing:** accepted only if n ≤ DEPTH − count, using count before this cycle's dequeue. Otherwise the whole cycle is dropped and overflow is set; overflow stays set until reset.
- **Dequeue:** one entry when out_valid && out_ready. Head is first-word-fall-through from storage.
- **Pointers:** head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is updated by +n_accepted − deq each cycle.
- **Failure:**
  - chk_valid && chk_code≠0 while fail=0 sets fail and captures fail_code.
  - Later codes are ignored.
  - When fail=1, out_valid is forced 0: the queue freezes and enqueue continues until full.
- **Finish:**
  - A sticky finish_req is set when tohost[0]=1 while reset is high.
  - finish = finish_req && count==0 && !fail, registered. So finish rises only after every buffered commit has drained.
  - fail=1 never asserts finish; the bench treats fail as terminal.
- **Reset (reset=0 at a clock edge):**
  - Clears pointers, count, overflow, fail, fail_code, finish_req, finish.
  - In-flight entries are discarded; payload storage is not cleared.
  - Reset mid-drain yields out_valid=0 next cycle.

## Timing
- Reset values: out_valid 0, count 0, overflow 0, fail 0, fail_code 0, finish 0. Payload outputs are don't-care while out_valid=0.
- Enqueue-to-out latency: events sampled at edge N appear at the head no earlier than cycle N+1 (no bypass).
- Drain throughput: one entry per cycle.
- Full: count==DEPTH gives out_valid=1 and drops all new events.
- Empty: out_valid=0, and out_ready is ignored.
- Simultaneous enq+deq at count==DEPTH−n+1: the cycle is dropped (conservative pre-dequeue check).
- fail rises the cycle after the failing strobe; out_valid falls in that same cycle.
- finish rises one cycle after count reaches 0 with finish_req set.

## Structure
- Shared package `difftest_pkg`:
  - `commit_entry_t` struct: kind, hartid, pc, inst, wdata, mstatus, check; widths from package localparams.
  - `KIND_COMMIT` / `KIND_TRAP` constants.
- One sub-module `difftest_lane_compactor`: combinational prefix-count mapping the valid lanes plus trap to write slots 0..n−1.
- Storage and pointer FSM live in the top module.

## Test plan
- **Two-lane ordering:** in_valid=2'b11, pc0=0x80000000, pc1=0x80000004, int_xcpt=1, cause=0x8000000000000007, out_ready=1 → three beats: pc 0x80000000, pc 0x80000004, then kind=1 with wdata=0x8000000000000007; count peaks at 3.
- **Lane gap:** in_valid=2'b10, pc1=0x1000 → single beat with pc 0x1000, kind=0.
- **Overflow:** out_ready=0, enqueue 2/cycle from empty with DEPTH=16 → count reaches 16 after 8 cycles; 9th cycle dropped, overflow=1, count stays 16.
- **Failure freeze:** stream 5 entries, chk_code=3 on the 2nd beat → fail=1, fail_code=3, out_valid=0 from next cycle, count=3, finish stays 0.
- **Finish gating:** 4 entries queued, tohost=1, out_ready=1 → finish rises exactly one cycle after count hits 0, not before.
- **Mid-drain reset:** reset=0 for one edge with count=6 → count=0, out_valid=0, overflow=0 next cycle; subsequent enqueue works from slot 0.

Source files
------------

// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest commit serializer.
package difftest_pkg;

    localparam int COMMIT_WIDTH = 2;
    localparam int XLEN         = 64;
    localparam int INST_BITS    = 32;
    localparam int HARTID_LEN   = 1;
    localparam int DEPTH        = 16;

    localparam logic KIND_COMMIT = 1'b0;
    localparam logic KIND_TRAP   = 1'b1;

    typedef struct packed {
        logic                  kind;
        logic [HARTID_LEN-1:0] hartid;
        logic [XLEN-1:0]       pc;
        logic [INST_BITS-1:0]  inst;
        logic [XLEN-1:0]       wdata;
        logic [XLEN-1:0]       mstatus;
        logic                  check;
    } commit_entry_t;

endpackage

// File: rtl/difftest_lane_compactor.sv
// Maps each valid commit lane (and the trap event, placed last) to a
// dense write slot 0..n-1 and reports the number of entries n.
module difftest_lane_compactor
    import difftest_pkg::*;
#(
    parameter int LANES  = COMMIT_WIDTH,
    parameter int SLOT_W = $clog2(LANES + 2)
) (
    input  logic [LANES-1:0]             lane_valid,
    input  logic                         trap,
    output logic [LANES:0][SLOT_W-1:0]   slot,
    output logic [SLOT_W-1:0]            n_entries
);

    logic [SLOT_W-1:0] prefix;

    // Running count of older valid lanes gives each lane its slot.
    always_comb begin
        prefix    = '0;
        slot      = '0;
        n_entries = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = prefix;
            prefix  = prefix + SLOT_W'(lane_valid[i]);
        end
        slot[LANES] = prefix;
        n_entries   = prefix + SLOT_W'(trap);
    end

endmodule

// File: rtl/difftest_commit_serializer.sv
// Buffers multi-lane commit/trap events and replays them one per cycle,
// in program order, to the co-simulation checker. Latches the first
// checker failure and holds off end-of-test until the queue has drained.
module difftest_commit_serializer
    import difftest_pkg::*;
#(
    parameter int COMMIT_WIDTH_P = COMMIT_WIDTH,
    parameter int XLEN_P         = XLEN,
    parameter int INST_BITS_P    = INST_BITS,
    parameter int HARTID_LEN_P   = HARTID_LEN,
    parameter int DEPTH_P        = DEPTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [COMMIT_WIDTH_P-1:0]          in_valid,
    input  logic [HARTID_LEN_P-1:0]            hartid,
    input  logic [XLEN_P*COMMIT_WIDTH_P-1:0]   pc,
    input  logic [XLEN_P*COMMIT_WIDTH_P-1:0]   wdata,
    input  logic [XLEN_P*COMMIT_WIDTH_P-1:0]   mstatus,
    input  logic [INST_BITS_P*COMMIT_WIDTH_P-1:0] inst,
    input  logic [COMMIT_WIDTH_P-1:0]          check,
    input  logic                               int_xcpt,
    input  logic [XLEN_P-1:0]                  cause,
    input  logic [XLEN_P-1:0]                  tohost,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_kind,
    output logic [HARTID_LEN_P-1:0]            out_hartid,
    output logic [XLEN_P-1:0]                  out_pc,
    output logic [XLEN_P-1:0]                  out_wdata,
    output logic [XLEN_P-1:0]                  out_mstatus,
    output logic [INST_BITS_P-1:0]             out_inst,
    output logic                               out_check,
    input  logic                               chk_valid,
    input  logic [31:0]                        chk_code,
    output logic [$clog2(DEPTH_P):0]           count,
    output logic                               overflow,
    output logic                               fail,
    output logic [31:0]                        fail_code,
    output logic                               finish
);

    localparam int PTR_W  = $clog2(DEPTH_P);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SRC    = COMMIT_WIDTH_P + 1;
    localparam int SLOT_W = $clog2(COMMIT_WIDTH_P + 2);

    commit_entry_t mem [DEPTH_P];
    commit_entry_t src_entry [SRC];
    commit_entry_t head_entry;

    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [CNT_W-1:0]            count_q;
    logic                        overflow_q;
    logic                        fail_q;
    logic [31:0]                 fail_code_q;
    logic                        finish_req;
    logic                        finish_q;

    logic [SRC-1:0]              src_valid;
    logic [SRC-1:0][SLOT_W-1:0]  slot;
    logic [SLOT_W-1:0]           n_entries;
    logic [CNT_W-1:0]            n_wide;
    logic [CNT_W-1:0]            space;
    logic                        enq_ok;
    logic                        drop;
    logic                        deq;
    logic                        unused_tohost;

    assign unused_tohost = ^tohost[XLEN_P-1:1];

    difftest_lane_compactor #(
        .LANES  (COMMIT_WIDTH_P),
        .SLOT_W (SLOT_W)
    ) u_compactor (
        .lane_valid (in_valid),
        .trap       (int_xcpt),
        .slot       (slot),
        .n_entries  (n_entries)
    );

    // Assemble one candidate entry per lane plus the trap entry.
    always_comb begin
        src_valid = {int_xcpt, in_valid};
        for (int i = 0; i < COMMIT_WIDTH_P; i++) begin
            src_entry[i].kind    = KIND_COMMIT;
            src_entry[i].hartid  = hartid;
            src_entry[i].pc      = pc[i*XLEN_P +: XLEN_P];
            src_entry[i].inst    = inst[i*INST_BITS_P +: INST_BITS_P];
            src_entry[i].wdata   = wdata[i*XLEN_P +: XLEN_P];
            src_entry[i].mstatus = mstatus[i*XLEN_P +: XLEN_P];
            src_entry[i].check   = check[i];
        end
        src_entry[SRC-1].kind    = KIND_TRAP;
        src_entry[SRC-1].hartid  = hartid;
        src_entry[SRC-1].pc      = '0;
        src_entry[SRC-1].inst    = '0;
        src_entry[SRC-1].wdata   = cause;
        src_entry[SRC-1].mstatus = '0;
        src_entry[SRC-1].check   = 1'b1;
    end

    // Admission uses occupancy before this cycle's dequeue, so a cycle is
    // either stored whole or dropped whole.
    always_comb begin
        n_wide = CNT_W'(n_entries);
        space  = CNT_W'(DEPTH_P) - count_q;
        enq_ok = (n_entries != '0) && (n_wide <= space);
        drop   = (n_entries != '0) && !enq_ok;
        deq    = out_valid && out_ready;
    end

    // Payload storage; never reset, validity is tracked by count.
    always_ff @(posedge clock) begin
        if (enq_ok) begin
            for (int i = 0; i < SRC; i++) begin
                if (src_valid[i]) begin
                    mem[tail + PTR_W'(slot[i])] <= src_entry[i];
                end
            end
        end
    end

    // Pointers, occupancy and sticky status flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= '0;
            finish_req  <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            if (enq_ok) begin
                tail <= tail + PTR_W'(n_entries);
            end
            count_q <= count_q + (enq_ok ? n_wide : '0) - CNT_W'(deq);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (chk_valid && (chk_code != '0) && !fail_q) begin
                fail_q      <= 1'b1;
                fail_code_q <= chk_code;
            end
            if (tohost[0]) begin
                finish_req <= 1'b1;
            end
            finish_q <= finish_req && (count_q == '0) && !fail_q;
        end
    end

    // First-word-fall-through head; a latched failure freezes the stream.
    always_comb begin
        head_entry  = mem[head];
        out_valid   = (count_q != '0) && !fail_q;
        out_kind    = head_entry.kind;
        out_hartid  = head_entry.hartid;
        out_pc      = head_entry.pc;
        out_wdata   = head_entry.wdata;
        out_mstatus = head_entry.mstatus;
        out_inst    = head_entry.inst;
        out_check   = head_entry.check;
        count       = count_q;
        overflow    = overflow_q;
        fail        = fail_q;
        fail_code   = fail_code_q;
        finish      = finish_q;
    end

endmodule

// File: tb/tb_difftest_commit_serializer.sv
// Directed bench for difftest_commit_serializer.
module tb_difftest_commit_serializer;
    import difftest_pkg::*;

    logic                          clock = 1'b0;
    logic                          reset;
    logic [COMMIT_WIDTH-1:0]       in_valid;
    logic [HARTID_LEN-1:0]         hartid;
    logic [XLEN*COMMIT_WIDTH-1:0]  pc;
    logic [XLEN*COMMIT_WIDTH-1:0]  wdata;
    logic [XLEN*COMMIT_WIDTH-1:0]  mstatus;
    logic [INST_BITS*COMMIT_WIDTH-1:0] inst;
    logic [COMMIT_WIDTH-1:0]       check;
    logic                          int_xcpt;
    logic [XLEN-1:0]               cause;
    logic [XLEN-1:0]               tohost;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_kind;
    logic [HARTID_LEN-1:0]         out_hartid;
    logic [XLEN-1:0]               out_pc;
    logic [XLEN-1:0]               out_wdata;
    logic [XLEN-1:0]               out_mstatus;
    logic [INST_BITS-1:0]          out_inst;
    logic                          out_check;
    logic                          chk_valid;
    logic [31:0]                   chk_code;
    logic [$clog2(DEPTH):0]        count;
    logic                          overflow;
    logic                          fail;
    logic [31:0]                   fail_code;
    logic                          finish;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    difftest_commit_serializer dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .hartid      (hartid),
        .pc          (pc),
        .wdata       (wdata),
        .mstatus     (mstatus),
        .inst        (inst),
        .check       (check),
        .int_xcpt    (int_xcpt),
        .cause       (cause),
        .tohost      (tohost),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_kind    (out_kind),
        .out_hartid  (out_hartid),
        .out_pc      (out_pc),
        .out_wdata   (out_wdata),
        .out_mstatus (out_mstatus),
        .out_inst    (out_inst),
        .out_check   (out_check),
        .chk_valid   (chk_valid),
        .chk_code    (chk_code),
        .count       (count),
        .overflow    (overflow),
        .fail        (fail),
        .fail_code   (fail_code),
        .finish      (finish)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid  = '0;
        int_xcpt  = 1'b0;
        chk_valid = 1'b0;
        chk_code  = '0;
        tohost    = '0;
    endtask

    task automatic lanes(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1);
        in_valid = v;
        pc       = {p1, p0};
        wdata    = {p1 + 64'h10, p0 + 64'h10};
        inst     = {p1[31:0] ^ 32'h13, p0[31:0] ^ 32'h13};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        hartid    = '0;
        pc        = '0;
        wdata     = '0;
        mstatus   = '0;
        inst      = '0;
        check     = '1;
        cause     = '0;
        out_ready = 1'b0;
        idle();
        step();
        step();
        reset = 1'b1;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count",     count,     0);
        chk("rst_overflow",  overflow,  0);
        chk("rst_fail",      fail,      0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_finish",    finish,    0);

        // Two-lane ordering with trap appended
        hartid    = 1'b1;
        lanes(2'b11, 64'h8000_0000, 64'h8000_0004);
        int_xcpt  = 1'b1;
        cause     = 64'h8000_0000_0000_0007;
        out_ready = 1'b1;
        step();
        idle();
        chk("ord_count3",  count,      3);
        chk("ord_valid",   out_valid,  1);
        chk("ord_pc0",     out_pc,     64'h8000_0000);
        chk("ord_kind0",   out_kind,   0);
        chk("ord_inst0",   out_inst,   32'h8000_0013);
        chk("ord_hartid",  out_hartid, 1);
        step();
        chk("ord_count2",  count,      2);
        chk("ord_pc1",     out_pc,     64'h8000_0004);
        chk("ord_kind1",   out_kind,   0);
        step();
        chk("ord_count1",  count,      1);
        chk("ord_kind2",   out_kind,   1);
        chk("ord_cause",   out_wdata,  64'h8000_0000_0000_0007);
        step();
        chk("ord_empty",   out_valid,  0);
        chk("ord_count0",  count,      0);
        hartid = 1'b0;

        // Lane gap: only lane 1 valid
        lanes(2'b10, 64'hdead, 64'h1000);
        step();
        idle();
        chk("gap_count",   count,      1);
        chk("gap_pc",      out_pc,     64'h1000);
        chk("gap_kind",    out_kind,   0);
        step();
        chk("gap_drained", count,      0);

        // Overflow: fill to DEPTH two per cycle, then drop
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            lanes(2'b11, 64'h2000 + 64'(8*k), 64'h2004 + 64'(8*k));
            step();
        end
        chk("ovf_full_count", count,    16);
        chk("ovf_not_yet",    overflow, 0);
        chk("ovf_full_valid", out_valid, 1);
        lanes(2'b11, 64'h9990, 64'h9994);
        step();
        chk("ovf_count_hold", count,    16);
        chk("ovf_sticky",     overflow, 1);
        idle();
        out_ready = 1'b1;
        step();
        chk("ovf_deq_count",  count,    15);
        chk("ovf_head1",      out_pc,   64'h2004);
        // Two entries against one free slot while dequeuing: dropped
        lanes(2'b11, 64'h7770, 64'h7774);
        step();
        idle();
        chk("ovf_conservative", count,  14);
        chk("ovf_head2",      out_pc,   64'h2008);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("ovf_drain_pc", out_pc, 64'h200c + 64'(4*k));
        end
        chk("ovf_count6",     count,    6);
        chk("ovf_still_set",  overflow, 1);

        // Mid-drain reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst_count",    count,     0);
        chk("mrst_valid",    out_valid, 0);
        chk("mrst_overflow", overflow,  0);
        out_ready = 1'b0;
        lanes(2'b01, 64'h3000, 64'h0);
        step();
        idle();
        chk("mrst_enq_count", count,    1);
        chk("mrst_enq_pc",    out_pc,   64'h3000);
        chk("mrst_enq_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("mrst_drained",   count,    0);

        // Failure freeze
        out_ready = 1'b0;
        lanes(2'b11, 64'h4000, 64'h4004);
        step();
        lanes(2'b11, 64'h4008, 64'h400c);
        step();
        lanes(2'b01, 64'h4010, 64'h0);
        step();
        idle();
        chk("fail_count5", count, 5);
        out_ready = 1'b1;
        chk_valid = 1'b1;
        chk_code  = 32'd0;
        step();
        chk("fail_pass_beat", fail, 0);
        chk_code = 32'd3;
        step();
        chk("fail_set",       fail,      1);
        chk("fail_code3",     fail_code, 3);
        chk("fail_frozen",    out_valid, 0);
        chk("fail_count3",    count,     3);
        chk_code = 32'd5;
        step();
        chk_valid = 1'b0;
        chk_code  = '0;
        chk("fail_code_keep", fail_code, 3);
        chk("fail_count_hold", count,    3);
        lanes(2'b11, 64'h4020, 64'h4024);
        step();
        idle();
        chk("fail_enq_cont",  count,     5);
        tohost = 64'h1;
        step();
        tohost = '0;
        step();
        chk("fail_no_finish", finish,    0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("fail_cleared",   fail,      0);

        // Finish gating
        out_ready = 1'b0;
        lanes(2'b11, 64'h5000, 64'h5004);
        step();
        lanes(2'b11, 64'h5008, 64'h500c);
        step();
        idle();
        tohost = 64'h1;
        step();
        tohost = '0;
        chk("fin_count4", count,  4);
        chk("fin_early",  finish, 0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("fin_drain_count", count,  4 - k);
            chk("fin_not_yet",     finish, 0);
        end
        step();
        chk("fin_rise", finish, 1);
        chk("fin_empty_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
